wb_byte_master: RTL

WB_BYTE_MASTER -- requirements
Module: wb_byte_master

---
 rtl/wb_byte_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_byte_master.sv
// wb_byte_master: decodes opcode/address/data command bytes into one Wishbone transfer
// and returns a status byte (plus read data). Define WB_BYTE_MASTER_TIMEOUT_EN for a bus timeout.
module wb_byte_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, STATUS, RDATA} state_t;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_OP  = 8'hFE;
  localparam logic [7:0] ST_TIMEOUT = 8'hFF;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_byte_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t     state;
  logic       is_write;
  logic [7:0] status;
  logic [7:0] rd_buf;
  logic       rx_fire;
  logic       start_bus;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
  // Counter holds the number of BUS cycles already spent without ack.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`endif

  assign rx_fire   = rx_valid && rx_ready;
  // The last command byte launches the bus cycle: address for reads, data for writes.
  assign start_bus = rx_fire && ((state == ADDR && !is_write) || state == DATA);

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked block
  // and is only seen at a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      is_write <= 1'b0;
      status   <= 8'h00;
      rd_buf   <= 8'h00;
      rx_ready <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      wb_adr_o <= 8'h00;
      wb_dat_o <= 8'h00;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
      tmo_cnt  <= 16'd0;
`endif
    end else begin
      // NOTE: every state register uses non-blocking assignment so all updates
      // in this block see pre-edge values, regardless of statement order.
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_write <= (rx_data == OP_WRITE);
              state    <= ADDR;
            end else begin
              status   <= ST_BAD_OP;
              tx_data  <= ST_BAD_OP;
              tx_valid <= 1'b1;
              rx_ready <= 1'b0;
              state    <= STATUS;
            end
          end
        end

        ADDR: begin
          if (rx_fire) begin
            wb_adr_o <= rx_data;
            if (is_write) state <= DATA;
          end
        end

        DATA: begin
          if (rx_fire) wb_dat_o <= rx_data;
        end

        BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (!is_write) rd_buf <= wb_dat_i;
            status   <= ST_OK;
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            rd_buf   <= 8'h00;
            status   <= ST_TIMEOUT;
            tx_data  <= ST_TIMEOUT;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        STATUS: begin
          if (tx_ready) begin
            // Reads that reached the bus always return a data byte, even after a timeout.
            if (!is_write && (status == ST_OK || status == ST_TIMEOUT)) begin
              tx_data <= rd_buf;
              state   <= RDATA;
            end else begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        RDATA: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          state    <= IDLE;
        end
      endcase

      if (start_bus) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= is_write;
        rx_ready <= 1'b0;
        state    <= BUS;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
        tmo_cnt  <= 16'd0;
`endif
      end
    end
  end

endmodule
